itcm_load_responder: RTL and testbench

ITCM_LOAD_RESPONDER -- requirements
Module: itcm_load_responder

---
 rtl/itcm_load_responder.sv | 153 +++++++++++++++
 tb/tb_itcm_load_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_load_responder.sv
// Single-outstanding ITCM auto-load responder: accepts a word address, fetches it from backing memory, returns it.
// Optional feature: define ITCM_LOAD_CHKSUM_EN to enable the rotate-and-add running checksum on load_checksum.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module itcm_load_responder (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   itcm_auto_load,
    input  logic [`ADDR_WIDTH-1:0] itcm_auto_load_addr,
    output logic                   IAXI_ready,
    output logic [`DATA_WIDTH-1:0] IAXI_read_data,
    output logic                   IAXI_read_data_valid,
    output logic                   mem_req,
    output logic [`ADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [`DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]            words_served,
    output logic [`DATA_WIDTH-1:0] load_checksum
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        FETCH,
        RESP
    } state_t;

    localparam logic [`ADDR_WIDTH-1:0] WORD_MASK = ~(`ADDR_WIDTH'(3));

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic                   req_q, req_d;
    logic [`ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [`ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [`DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]            words_q, words_d;
    logic                   load_q, load_d;
    logic                   load_rise;

    assign load_rise = itcm_auto_load & ~load_q;

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        valid_d    = 1'b0;
        req_d      = req_q;
        mem_addr_d = mem_addr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        load_d     = itcm_auto_load;

        case (state_q)
            IDLE: begin
                if (itcm_auto_load) begin
                    addr_d  = itcm_auto_load_addr & WORD_MASK;
                    ready_d = 1'b1;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                req_d      = 1'b1;
                mem_addr_d = addr_q;
                state_d    = FETCH;
            end
            FETCH: begin
                // Only FETCH listens to mem_ack; stray acks elsewhere fall through.
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        words_d = words_q;
        if (load_rise) begin
            words_d = 16'd0;
        end else if (state_q == RESP) begin
            words_d = words_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            mem_addr_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            words_q    <= '0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            mem_addr_q <= mem_addr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            words_q    <= words_d;
            load_q     <= load_d;
        end
    end

`ifdef ITCM_LOAD_CHKSUM_EN
    logic [`DATA_WIDTH-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (load_rise) begin
            chk_d = '0;
        end else if (state_q == RESP) begin
            chk_d = {chk_q[`DATA_WIDTH-2:0], chk_q[`DATA_WIDTH-1]} + data_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign load_checksum = chk_q;
`else
    assign load_checksum = '0;
`endif

    assign IAXI_ready           = ready_q;
    assign IAXI_read_data_valid = valid_q;
    assign IAXI_read_data       = data_q;
    assign mem_req              = req_q;
    assign mem_addr             = mem_addr_q;
    assign words_served         = words_q;

endmodule

// File: tb/tb_itcm_load_responder.sv
// Randomized self-checking bench for itcm_load_responder against a transaction-level reference model.
// Honours ITCM_LOAD_CHKSUM_EN the same way the design does.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_itcm_load_responder;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   itcm_auto_load;
    logic [`ADDR_WIDTH-1:0] itcm_auto_load_addr;
    logic                   IAXI_ready;
    logic [`DATA_WIDTH-1:0] IAXI_read_data;
    logic                   IAXI_read_data_valid;
    logic                   mem_req;
    logic [`ADDR_WIDTH-1:0] mem_addr;
    logic                   mem_ack;
    logic [`DATA_WIDTH-1:0] mem_rdata;
    logic [15:0]            words_served;
    logic [`DATA_WIDTH-1:0] load_checksum;

    int          vecCount  = 0;
    int          failCount = 0;
    logic [15:0] modelWords;
    logic [31:0] modelChk;

    always #5 clk = ~clk;

    itcm_load_responder dut (
        .clk                 (clk),
        .rstn                (rstn),
        .itcm_auto_load      (itcm_auto_load),
        .itcm_auto_load_addr (itcm_auto_load_addr),
        .IAXI_ready          (IAXI_ready),
        .IAXI_read_data      (IAXI_read_data),
        .IAXI_read_data_valid(IAXI_read_data_valid),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .words_served        (words_served),
        .load_checksum       (load_checksum)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference checksum: rotate left by one, then add, modulo 2^32.
    function automatic logic [31:0] chkStep(input logic [31:0] c, input logic [31:0] d);
        return ((c << 1) | (c >> 31)) + d;
    endfunction

    function automatic logic [31:0] expChk();
`ifdef ITCM_LOAD_CHKSUM_EN
        return modelChk;
`else
        return 32'h0;
`endif
    endfunction

    // One full request/response exchange, checked cycle by cycle; the bench plays the backing memory.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input int ackDelay, input bit dropInFetch, input bit junkAck);
        int          reqCycles;
        logic [31:0] expAddr;
        reqCycles = 0;
        expAddr   = addr & 32'hFFFF_FFFC;
        if (!itcm_auto_load) begin
            modelWords = 16'd0;
            modelChk   = 32'h0;
        end
        itcm_auto_load      = 1'b1;
        itcm_auto_load_addr = addr;
        mem_ack             = junkAck;
        mem_rdata           = ~data;
        tick;
        checkOutput("ready_accept", 32'(IAXI_ready), 32'h1);
        checkOutput("req_accept", 32'(mem_req), 32'h0);
        checkOutput("valid_accept", 32'(IAXI_read_data_valid), 32'h0);
        itcm_auto_load_addr = $urandom;
        tick;
        for (int i = 0; i <= ackDelay; i++) begin
            checkOutput("ready_fetch", 32'(IAXI_ready), 32'h0);
            checkOutput("addr_fetch", mem_addr, expAddr);
            checkOutput("valid_fetch", 32'(IAXI_read_data_valid), 32'h0);
            reqCycles += int'(mem_req);
            if (dropInFetch) itcm_auto_load = 1'b0;
            mem_ack   = (i == ackDelay);
            mem_rdata = (i == ackDelay) ? data : $urandom;
            tick;
        end
        mem_ack   = junkAck;
        mem_rdata = $urandom;
        checkOutput("req_cycles", reqCycles, ackDelay + 1);
        checkOutput("valid_resp", 32'(IAXI_read_data_valid), 32'h1);
        checkOutput("data_resp", IAXI_read_data, data);
        checkOutput("req_resp", 32'(mem_req), 32'h0);
        checkOutput("ready_resp", 32'(IAXI_ready), 32'h0);
        modelWords = modelWords + 16'd1;
        modelChk   = chkStep(modelChk, data);
        tick;
        mem_ack = 1'b0;
        checkOutput("valid_after", 32'(IAXI_read_data_valid), 32'h0);
        checkOutput("ready_after", 32'(IAXI_ready), 32'h0);
        checkOutput("data_hold", IAXI_read_data, data);
        checkOutput("words", 32'(words_served), 32'(modelWords));
        checkOutput("chksum", load_checksum, expChk());
    endtask

    initial begin
        logic [31:0] d1;
        rstn                = 1'b0;
        itcm_auto_load      = 1'b0;
        itcm_auto_load_addr = '0;
        mem_ack             = 1'b0;
        mem_rdata           = '0;
        modelWords          = 16'd0;
        modelChk            = 32'h0;
        repeat (3) tick;
        checkOutput("rst_ready", 32'(IAXI_ready), 32'h0);
        checkOutput("rst_req", 32'(mem_req), 32'h0);
        checkOutput("rst_words", 32'(words_served), 32'h0);
        checkOutput("rst_data", IAXI_read_data, 32'h0);
        rstn = 1'b1;
        tick;

        $display("[TB] basic fetch, then back-to-back with load held");
        applyStimulus(32'h0000_0004, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        checkOutput("words_first", 32'(words_served), 32'h1);
        applyStimulus(32'h0000_0008, 32'h1234_5678, 0, 1'b0, 1'b1);
        itcm_auto_load = 1'b0;
        tick;

        $display("[TB] delayed ack and unaligned address");
        applyStimulus(32'h0000_0100, $urandom, 5, 1'b0, 1'b1);
        itcm_auto_load = 1'b0;
        tick;
        applyStimulus(32'h0000_0013, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
        itcm_auto_load = 1'b0;
        tick;

        $display("[TB] load dropped during fetch");
        applyStimulus(32'h0000_0020, 32'h0BAD_CAFE, 2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            tick;
            checkOutput("no_ready_after_drop", 32'(IAXI_ready), 32'h0);
            checkOutput("no_valid_after_drop", 32'(IAXI_read_data_valid), 32'h0);
        end
        mem_ack = 1'b0;

        $display("[TB] checksum sequence");
        applyStimulus(32'h0000_0008, 32'h0000_0001, 0, 1'b0, 1'b0);
`ifdef ITCM_LOAD_CHKSUM_EN
        checkOutput("chk_first", load_checksum, 32'h0000_0001);
`else
        checkOutput("chk_first", load_checksum, 32'h0);
`endif
        applyStimulus(32'h0000_000C, 32'h8000_0000, 1, 1'b0, 1'b0);
`ifdef ITCM_LOAD_CHKSUM_EN
        checkOutput("chk_second", load_checksum, 32'h8000_0002);
`else
        checkOutput("chk_second", load_checksum, 32'h0);
`endif
        itcm_auto_load = 1'b0;
        tick;

        $display("[TB] reset mid-fetch");
        itcm_auto_load      = 1'b1;
        itcm_auto_load_addr = 32'h0000_0040;
        tick;
        tick;
        checkOutput("req_before_rst", 32'(mem_req), 32'h1);
        #2;
        rstn           = 1'b0;
        itcm_auto_load = 1'b0;
        #1;
        checkOutput("rst_async_req", 32'(mem_req), 32'h0);
        checkOutput("rst_async_addr", mem_addr, 32'h0);
        checkOutput("rst_async_data", IAXI_read_data, 32'h0);
        checkOutput("rst_async_words", 32'(words_served), 32'h0);
        checkOutput("rst_async_chk", load_checksum, 32'h0);
        checkOutput("rst_async_valid", 32'(IAXI_read_data_valid), 32'h0);
        modelWords = 16'd0;
        modelChk   = 32'h0;
        tick;
        rstn      = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput("late_ack_valid", 32'(IAXI_read_data_valid), 32'h0);
            checkOutput("late_ack_ready", 32'(IAXI_ready), 32'h0);
            checkOutput("late_ack_req", 32'(mem_req), 32'h0);
        end
        mem_ack = 1'b0;

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                itcm_auto_load = 1'b0;
                repeat (gap) tick;
            end
            d1 = $urandom;
            applyStimulus($urandom, d1, $urandom_range(0, 6), 1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
